// File: rtl/dac_pkg.sv
// Shared types and helpers for the unary DAC decoder path.
// Holds the mode encoding and the unit-count function.
package dac_pkg;

    typedef enum logic [1:0] {
        DAC_MODE_THERM = 2'b00,
        DAC_MODE_DWA   = 2'b01
    } dac_mode_e;

    function automatic int units(input int n);
        return (1 << n) - 1;
    endfunction

endpackage

// File: rtl/dac_therm_decode.sv
// Combinational binary-to-thermometer decode.
// Bit k is set when the code exceeds k.
module dac_therm_decode
    import dac_pkg::*;
#(
    parameter  int N_BITS = 3,
    localparam int M      = units(N_BITS)
) (
    input  logic [N_BITS-1:0] b_in,
    output logic [M-1:0]      therm_o
);

    always_comb begin
        therm_o = '0;
        for (int k = 0; k < M; k++) begin
            therm_o[k] = (32'(b_in) > 32'(k));
        end
    end

endmodule

// File: rtl/dac_dwa_decoder.sv
// Registered thermometer decoder with optional data-weighted averaging.
// DWA rotates the base pattern by a running start pointer.
module dac_dwa_decoder
    import dac_pkg::*;
#(
    parameter  int N_BITS = 3,
    localparam int M      = units(N_BITS),
    localparam int PW     = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic              clr_ptr_i,
    input  logic [N_BITS-1:0] b_in,
    output logic [M-1:0]      t_out,
    output logic              valid_o,
    output logic [PW-1:0]     ptr_o
);

    logic          dwa;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] p_eff;
    logic [PW-1:0] ptr_nxt;
    logic [PW:0]   sum;
    logic [PW:0]   sum_w;
    logic [M-1:0]  base;
    logic [2*M-1:0] dbl;
    logic [M-1:0]  rot;

    assign dwa = (mode_i == DAC_MODE_DWA);

    dac_therm_decode #(
        .N_BITS (N_BITS)
    ) u_therm (
        .b_in    (b_in),
        .therm_o (base)
    );

    // A clear in the same edge makes the sample start at unit 0
    assign p_eff = (dwa && !clr_ptr_i) ? ptr_q : '0;

    // Rotating a doubled copy keeps the rotate a single shift
    assign dbl = {base, base} << p_eff;
    assign rot = dbl[2*M-1:M];

    always_comb begin
        sum   = (PW+1)'(p_eff) + (PW+1)'(b_in);
        sum_w = sum;
        if (sum >= (PW+1)'(M)) begin
            sum_w = sum - (PW+1)'(M);
        end
        ptr_nxt = sum_w[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_out   <= '0;
            valid_o <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_o <= en_i;
            if (en_i) begin
                t_out <= rot;
            end
            if (en_i && dwa) begin
                ptr_q <= ptr_nxt;
            end else if (clr_ptr_i) begin
                ptr_q <= '0;
            end
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: tb/tb_dac_dwa_decoder.sv
// Directed bench for the DWA decoder at N_BITS=3 and a
// randomized DWA balance run at N_BITS=4.
module tb_dac_dwa_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3 = 1'b0;
    logic       en3 = 1'b0;
    logic [1:0] mode3 = 2'b00;
    logic       clr3 = 1'b0;
    logic [2:0] b3 = '0;
    logic [6:0] t3;
    logic       v3;
    logic [2:0] p3;

    logic        rst4 = 1'b0;
    logic        en4 = 1'b0;
    logic [1:0]  mode4 = 2'b01;
    logic        clr4 = 1'b0;
    logic [3:0]  b4 = '0;
    logic [14:0] t4;
    logic        v4;
    logic [3:0]  p4;

    int checks = 0;
    int errors = 0;

    dac_dwa_decoder #(.N_BITS(3)) d3 (
        .clk       (clk),
        .rst_n     (rst3),
        .en_i      (en3),
        .mode_i    (mode3),
        .clr_ptr_i (clr3),
        .b_in      (b3),
        .t_out     (t3),
        .valid_o   (v3),
        .ptr_o     (p3)
    );

    dac_dwa_decoder #(.N_BITS(4)) d4 (
        .clk       (clk),
        .rst_n     (rst4),
        .en_i      (en4),
        .mode_i    (mode4),
        .clr_ptr_i (clr4),
        .b_in      (b4),
        .t_out     (t4),
        .valid_o   (v4),
        .ptr_o     (p4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic s3(input logic e, input logic [1:0] m,
                      input logic c, input logic [2:0] b);
        en3 = e; mode3 = m; clr3 = c; b3 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic c3(input string tag, input logic [6:0] t,
                      input logic v, input logic [2:0] p);
        chk({tag, ".t"}, 32'(t3), 32'(t));
        chk({tag, ".v"}, 32'(v3), 32'(v));
        chk({tag, ".p"}, 32'(p3), 32'(p));
    endtask

    int          usage [15];
    int          mp;
    int          c;
    int          umax;
    int          umin;
    logic [14:0] exp4;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        c3("rst", 7'b0000000, 1'b0, 3'd0);
        rst3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s3(1'b0, 2'b00, 1'b0, 3'd0);
            c3("idle", 7'b0000000, 1'b0, 3'd0);
        end

        for (int b = 0; b < 8; b++) begin
            logic [7:0] one;
            one = 8'd1 << b;
            s3(1'b1, 2'b00, 1'b0, 3'(b));
            c3("therm", 7'(one - 8'd1), 1'b1, 3'd0);
        end

        s3(1'b1, 2'b01, 1'b0, 3'd3);
        c3("dwa3a", 7'b0000111, 1'b1, 3'd3);
        s3(1'b1, 2'b01, 1'b0, 3'd3);
        c3("dwa3b", 7'b0111000, 1'b1, 3'd6);
        s3(1'b1, 2'b01, 1'b0, 3'd3);
        c3("dwa3c", 7'b1000011, 1'b1, 3'd2);

        s3(1'b1, 2'b01, 1'b0, 3'd7);
        c3("full", 7'b1111111, 1'b1, 3'd2);
        s3(1'b1, 2'b01, 1'b0, 3'd0);
        c3("zero", 7'b0000000, 1'b1, 3'd2);

        s3(1'b1, 2'b01, 1'b0, 3'd3);
        c3("to5", 7'b0011100, 1'b1, 3'd5);
        s3(1'b1, 2'b01, 1'b1, 3'd2);
        c3("clr_en", 7'b0000011, 1'b1, 3'd2);

        s3(1'b0, 2'b01, 1'b0, 3'd5);
        c3("hold", 7'b0000011, 1'b0, 3'd2);
        s3(1'b1, 2'b00, 1'b0, 3'd3);
        c3("th_keep", 7'b0000111, 1'b1, 3'd2);
        s3(1'b1, 2'b01, 1'b0, 3'd1);
        c3("dwa_res", 7'b0000100, 1'b1, 3'd3);
        s3(1'b1, 2'b10, 1'b0, 3'd2);
        c3("rsvd", 7'b0000011, 1'b1, 3'd3);
        s3(1'b0, 2'b01, 1'b1, 3'd0);
        c3("clr_idle", 7'b0000011, 1'b0, 3'd0);
        s3(1'b1, 2'b01, 1'b0, 3'd4);
        c3("dwa_p0", 7'b0001111, 1'b1, 3'd4);
        s3(1'b1, 2'b00, 1'b1, 3'd1);
        c3("clr_th", 7'b0000001, 1'b1, 3'd0);
        s3(1'b1, 2'b01, 1'b0, 3'd6);
        c3("pre_rst", 7'b0111111, 1'b1, 3'd6);
        rst3 = 1'b0;
        #1;
        c3("async", 7'b0000000, 1'b0, 3'd0);
        s3(1'b1, 2'b01, 1'b0, 3'd5);
        c3("in_rst", 7'b0000000, 1'b0, 3'd0);
        en3 = 1'b0;

        rst4 = 1'b1;
        mp = 0;
        for (int u = 0; u < 15; u++) usage[u] = 0;
        for (int n = 0; n < 1000; n++) begin
            c = $urandom_range(0, 15);
            en4 = 1'b1;
            b4 = 4'(c);
            @(posedge clk);
            #1;
            exp4 = '0;
            for (int i = 0; i < c; i++) exp4[(mp + i) % 15] = 1'b1;
            chk("pop4", 32'($countones(t4)), 32'(c));
            chk("t4", 32'(t4), 32'(exp4));
            for (int u = 0; u < 15; u++) usage[u] += int'(t4[u]);
            if (mp + c >= 15) begin
                umax = usage[0];
                umin = usage[0];
                for (int u = 1; u < 15; u++) begin
                    if (usage[u] > umax) umax = usage[u];
                    if (usage[u] < umin) umin = usage[u];
                end
                chk("bal4", 32'(umax - umin <= 1), 32'd1);
            end
            mp = (mp + c) % 15;
            chk("p4", 32'(p4), 32'(mp));
            if (n == 500) begin
                rst4 = 1'b0;
                #1;
                chk("rst4.t", 32'(t4), 32'd0);
                chk("rst4.v", 32'(v4), 32'd0);
                chk("rst4.p", 32'(p4), 32'd0);
                rst4 = 1'b1;
                mp = 0;
                for (int u = 0; u < 15; u++) usage[u] = 0;
            end
        end
        en4 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_dwa_decoder.md
# dac_dwa_decoder

Parametrised, registered binary-to-thermometer decoder for the unary DAC array, with an optional data-weighted-averaging (DWA) mode. In DWA mode the active unit elements rotate cyclically across samples to first-order shape element mismatch. It sits between the sample source and the unit-element switch drivers. It is the clocked, N-bit successor of the fixed 3-bit thermometer decoder.

## Interface
Parameters:
- N_BITS, 3, input code width; unit count M = 2^N_BITS − 1 (N_BITS = 2..6)
- PW, $clog2(M), pointer width (derived, not overridden)

Ports:
- clk  in  1  sample clock
- rst_n  in  1  reset, asynchronous, active-low
- en_i  in  1  sample strobe; b_in is consumed on a rising clk edge where en_i = 1
- mode_i  in  2  00 = plain thermometer, 01 = DWA, 10/11 reserved and decoded as thermometer
- clr_ptr_i  in  1  synchronous DWA pointer clear
- b_in  in  N_BITS  unsigned input code, 0..M
- t_out  out  M  registered unit-element enables; bit k drives unit k
- valid_o  out  1  one-cycle pulse marking the cycle after a consumed sample
- ptr_o  out  PW  current DWA start pointer, range 0..M−1

## Operation
- Reset (rst_n low, asynchronous): t_out = 0, valid_o = 0, ptr = 0. All three hold while rst_n is low.
- en_i = 0: t_out and ptr hold; valid_o = 0.
- Thermometer mode, en_i = 1:
  - t_out[k] = 1 for k < b_in, else 0.
  - ptr is unchanged.
- DWA mode, en_i = 1, with code c = b_in and start pointer p:
  - t_out[(p + i) mod M] = 1 for i = 0..c−1; all other bits are 0.
  - Next ptr = (p + c) mod M. The sum is computed at PW+1 bits and uses a single conditional subtract of M.
  - c = M sets all bits, and ptr is unchanged. c = 0 gives t_out = 0, ptr is unchanged, and valid_o still pulses.
- clr_ptr_i = 1 has priority over the pointer update.
  - With en_i = 0: ptr ← 0.
  - With en_i = 1 in DWA mode: the sample uses p = 0, and ptr ← c mod M in the same edge.
  - With en_i = 1 in thermometer mode: ptr ← 0.
- Mode change: takes effect on the next consumed sample. The pointer is preserved across thermometer periods and is not reset by a mode change.
- popcount(t_out) = last consumed code, in every mode, always.

## Timing
- Latency: 1 clk. b_in sampled at edge n appears on t_out immediately after edge n. valid_o is high for the cycle from edge n to edge n+1.
- Back-to-back samples (en_i high every cycle) are supported at full rate. valid_o stays high continuously in that case.
- ptr_o is registered and reflects the pointer to be used by the next sample.
- Reset deassertion: the first edge with rst_n high may consume a sample.
- Asserting rst_n mid-stream clears outputs immediately, without waiting for a clock edge.
- t_out is glitch-free at the register boundary. No combinational path exists from inputs to outputs.

## Structure
- Shared package dac_pkg holds:
  - the mode typedef (DAC_MODE_THERM = 2'b00, DAC_MODE_DWA = 2'b01)
  - the unit-count helper function units(n) = 2^n − 1
- Sub-module dac_therm_decode (combinational, parametrised N_BITS) produces the base thermometer vector.
- The top applies a circular left-rotate by p over M bits. The rotate is in DWA mode only; in thermometer mode the rotate amount is 0.
- The top also owns the pointer, output and valid registers.

## Test plan
N_BITS = 3, M = 7 unless stated.
- Reset, then hold rst_n high with en_i = 0 for 5 cycles → t_out = 0000000, valid_o = 0, ptr_o = 0 throughout.
- Thermometer mode, b_in = 0..7 on consecutive en_i cycles → t_out = 0000000, 0000001, 0000011 … 1111111 one cycle later each; ptr_o stays 0.
- DWA mode, codes 3, 3, 3 → t_out = 0000111, 0111000, 1000011; ptr_o = 3, 6, 2.
- DWA from ptr 2, code 7 then code 0 → t_out = 1111111 then 0000000; ptr_o stays 2; valid_o pulses on both samples.
- ptr_o = 5, clr_ptr_i = 1 with en_i = 1 and code 2 in DWA mode → t_out = 0000011, ptr_o = 2.
- N_BITS = 4, random DWA codes over 1000 samples with rst_n pulsed low mid-stream:
  - popcount(t_out) always equals the code.
  - each of the 15 units' usage counts differ by ≤ 1 at every pointer-wrap point.
  - outputs are zero immediately on rst_n low.
